// File: rtl/gate_serial_sched.sv
// gate_serial_sched
//   Round-robin scheduler that shares one bit-serial gate unit among four
//   requesters. The winner's opcode and operands are latched at grant time.
//   They are then evaluated one bit per cycle, LSB first. The finished
//   WIDTH-bit result is returned with a one-cycle done pulse and the
//   requester id.
//
//   Optional feature macro: GATE_SCHED_ERR_EN
//     defined   -> adds output err, which is raised with done when the
//                  latched opcode is reserved (101-111)
//     undefined -> no err port; a reserved opcode silently yields result 0
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   req      in   [3:0]          level request per requester, held until done
//   op       in   [11:0]         op[3i+2:3i] = opcode of requester i
//   a        in   [4*WIDTH-1:0]  a[i*WIDTH +: WIDTH] = operand A of requester i
//   b        in   [4*WIDTH-1:0]  b[i*WIDTH +: WIDTH] = operand B of requester i
//   grant    out  [3:0]          one-hot owner of the unit, 0 when idle
//   busy     out                 high in RUN and DONE
//   done     out                 1-cycle pulse; result and done_id are valid
//   done_id  out  [1:0]          index of the finished requester
//   result   out  [WIDTH-1:0]    last result, held until the next done
//   err      out                 (GATE_SCHED_ERR_EN only) reserved opcode seen
//
// state  | meaning
// IDLE   | waiting for any req; arbitrate and latch operands
// RUN    | evaluate one bit per cycle, cnt = bit index
// DONE   | single cycle with done high and grant still held
module gate_serial_sched #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [11:0]        op,
  input  logic [4*WIDTH-1:0] a,
  input  logic [4*WIDTH-1:0] b,
  output logic [3:0]         grant,
  output logic               busy,
  output logic               done,
  output logic [1:0]         done_id,
  output logic [WIDTH-1:0]   result
`ifdef GATE_SCHED_ERR_EN
  ,
  output logic               err
`endif
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [1:0]       ptr;
  logic [2:0]       op_l;
  logic [WIDTH-1:0] a_l;
  logic [WIDTH-1:0] b_l;
  // Only WIDTH-1 bits are stored. The last bit goes straight into result
  // together with this register, so the LSB of a full-width register would
  // never be read.
  logic [WIDTH-2:0] result_sh;

  logic [1:0]       win;
  logic             found;
  logic [1:0]       idx;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             gate_out;
  logic [WIDTH-1:0] sh_next;

  function automatic logic gate_bit(input logic [2:0] o, input logic x, input logic y);
    case (o)
      3'b000:  gate_bit = ~x;
      3'b001:  gate_bit = ~(x & y);
      3'b010:  gate_bit = x & y;
      3'b011:  gate_bit = x | y;
      3'b100:  gate_bit = x ^ y;
      default: gate_bit = 1'b0;
    endcase
  endfunction

  // Scan ptr+1, ptr+2, ptr+3, ptr (mod 4). The last served requester is
  // checked last, which prevents starvation.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    op_sel = 3'd0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) == win) begin
        op_sel = op[3*i +: 3];
        a_sel  = a[i*WIDTH +: WIDTH];
        b_sel  = b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign gate_out = gate_bit(op_l, a_l[cnt], b_l[cnt]);
  assign sh_next  = {gate_out, result_sh};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ptr       <= 2'd3;
      op_l      <= 3'd0;
      a_l       <= '0;
      b_l       <= '0;
      result_sh <= '0;
      grant     <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= 2'd0;
      result    <= '0;
`ifdef GATE_SCHED_ERR_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req != 4'd0) begin
            grant <= 4'd1 << win;
            ptr   <= win;
            op_l  <= op_sel;
            a_l   <= a_sel;
            b_l   <= b_sel;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          result_sh <= sh_next[WIDTH-1:1];
          cnt       <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            result  <= sh_next;
            done    <= 1'b1;
            done_id <= ptr;
`ifdef GATE_SCHED_ERR_EN
            err     <= (op_l > 3'd4);
`endif
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          grant <= 4'd0;
          busy  <= 1'b0;
          done  <= 1'b0;
`ifdef GATE_SCHED_ERR_EN
          err   <= 1'b0;
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_serial_sched.sv
module tb_gate_serial_sched;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [11:0]  op;
  logic [4*W-1:0] a;
  logic [4*W-1:0] b;
  logic [3:0]   grant;
  logic         busy;
  logic         done;
  logic [1:0]   done_id;
  logic [W-1:0] result;
`ifdef GATE_SCHED_ERR_EN
  logic         err;
`endif

  int checks   = 0;
  int failures = 0;

  gate_serial_sched #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .op      (op),
    .a       (a),
    .b       (b),
    .grant   (grant),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .result  (result)
`ifdef GATE_SCHED_ERR_EN
    ,
    .err     (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [2:0] opc;
    logic [7:0] av;
    logic [7:0] bv;
    logic [7:0] exp;
    logic       exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input int id, input logic [2:0] o, input logic [7:0] av,
                        input logic [7:0] bv, input logic [7:0] exp, input logic ee);
    logic [7:0] prev;
    int n;
    prev = result;
    op = 12'h0; a = '0; b = '0;
    op[3*id +: 3] = o;
    a[id*W +: W] = av;
    b[id*W +: W] = bv;
    req = 4'd1 << id;
    tick();
    chk("grant", 32'(grant), 32'(4'd1 << id));
    chk("busy_run", 32'(busy), 1);
    chk("done_early", 32'(done), 0);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
      if (n == 4) chk("result_hold_run", 32'(result), 32'(prev));
    end
    chk("latency", n, W);
    chk("result", 32'(result), 32'(exp));
    chk("done_id", 32'(done_id), id);
    chk("grant_done", 32'(grant), 32'(4'd1 << id));
`ifdef GATE_SCHED_ERR_EN
    chk("err_done", 32'(err), 32'(ee));
`else
    if (ee) chk("reserved_result", 32'(result), 0);
`endif
    req = 4'd0;
    tick();
    chk("done_clear", 32'(done), 0);
    chk("busy_clear", 32'(busy), 0);
    chk("grant_clear", 32'(grant), 0);
`ifdef GATE_SCHED_ERR_EN
    chk("err_clear", 32'(err), 0);
`endif
    tick();
    chk("result_held", 32'(result), 32'(exp));
  endtask

  initial begin
    int n;
    int done_seen;
    logic [3:0] exp_g [5];
    logic [7:0] nand_exp [4];

    vecs[0] = '{0, 3'b100, 8'hF0, 8'hAA, 8'h5A, 1'b0};
    vecs[1] = '{1, 3'b001, 8'hF0, 8'hAA, 8'h5F, 1'b0};
    vecs[2] = '{2, 3'b010, 8'hCC, 8'hAA, 8'h88, 1'b0};
    vecs[3] = '{3, 3'b011, 8'hC0, 8'h0A, 8'hCA, 1'b0};
    vecs[4] = '{2, 3'b000, 8'h3C, 8'hFF, 8'hC3, 1'b0};
    vecs[5] = '{1, 3'b110, 8'hFF, 8'hFF, 8'h00, 1'b1};
    vecs[6] = '{0, 3'b001, 8'h00, 8'h00, 8'hFF, 1'b0};
    vecs[7] = '{3, 3'b111, 8'h12, 8'h34, 8'h00, 1'b1};
    vecs[8] = '{1, 3'b101, 8'hAA, 8'h55, 8'h00, 1'b1};

    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    nand_exp[0] = 8'h0F; nand_exp[1] = 8'hF0; nand_exp[2] = 8'hCC; nand_exp[3] = 8'hAA;

    // reset and idle
    reset = 1'b1; req = 4'd0; op = 12'h0; a = '0; b = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_done_id", 32'(done_id), 0);
    tick(); tick(); tick();
    chk("idle_grant", 32'(grant), 0);
    chk("idle_busy", 32'(busy), 0);

    // all four requesting NAND from reset pointer: 0,1,2,3,0
    op = 12'b001_001_001_001;
    a = {8'h55, 8'h33, 8'h0F, 8'hF0};
    b = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (grant == 4'd0 && n < 30) begin tick(); n++; end
      chk("rr_grant", 32'(grant), 32'(exp_g[k]));
      n = 0;
      while (!done && n < 30) begin tick(); n++; end
      chk("rr_done_id", 32'(done_id), (k == 4) ? 0 : k);
      chk("rr_result", 32'(result), 32'(nand_exp[k % 4]));
      tick();
      chk("rr_gap", 32'(grant), 0);
    end
    req = 4'd0;
    tick(); tick();

    // table-driven single-requester operations
    for (int v = 0; v < 9; v++)
      run_op(vecs[v].id, vecs[v].opc, vecs[v].av, vecs[v].bv, vecs[v].exp, vecs[v].exp_err);

    // INV with req dropped and operands changed mid-RUN
    op = 12'h0; a = '0; b = '0;
    op[8:6] = 3'b000; a[23:16] = 8'h3C; b[23:16] = 8'h55;
    req = 4'b0100;
    tick();
    chk("inv_grant", 32'(grant), 32'(4'b0100));
    tick(); tick(); tick();
    req = 4'd0; a[23:16] = 8'h00; op[8:6] = 3'b010;
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk("inv_done", 32'(done), 1);
    chk("inv_result", 32'(result), 32'(8'hC3));
    chk("inv_done_id", 32'(done_id), 2);
    tick(); tick();

    // reset mid-RUN aborts without a done pulse
    op = 12'h0; a = '0; b = '0;
    op[5:3] = 3'b010; a[15:8] = 8'hFF; b[15:8] = 8'hFF;
    req = 4'b0010;
    tick();
    chk("abort_grant", 32'(grant), 32'(4'b0010));
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; req = 4'd0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_grant0", 32'(grant), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_result", 32'(result), 0);
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    run_op(1, 3'b010, 8'h0F, 8'hFF, 8'h0F, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
